// File: rtl/pipeline_fetch_unit.sv
// pipeline_fetch_unit: PC register, ROM addressing with stall replay, IF/ID latch and stall counter
module pipeline_fetch_unit #(
  parameter int PC_WIDTH = 10,
  parameter int INSTR_WIDTH = 18,
  parameter logic [PC_WIDTH-1:0] INT_VECTOR = 10'h3FF,
  parameter logic [INSTR_WIDTH-1:0] NOP_INSTR = 18'h00000,
  parameter int CNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   pc_reset,
  input  logic                   int_taken,
  input  logic                   pc_load,
  input  logic [PC_WIDTH-1:0]    pc_load_addr,
  input  logic                   pc_inc,
  input  logic                   fetch_latch_stall,
  input  logic                   imem_addr_mux,
  input  logic                   dec_nop,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  output logic [PC_WIDTH-1:0]    pc,
  output logic [INSTR_WIDTH-1:0] if_instr,
  output logic [PC_WIDTH-1:0]    if_pc,
  output logic                   if_valid,
  output logic [CNT_WIDTH-1:0]   stall_count
);
  typedef enum logic [1:0] {FILL, RUN, HOLD} state_t;
  state_t state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, addr_q, addr_d, if_pc_q, if_pc_d;
  logic [INSTR_WIDTH-1:0] if_instr_q, if_instr_d;
  logic if_valid_q, if_valid_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic redirect, hold, bubble;
  assign redirect = pc_reset | int_taken | pc_load;
  assign hold = fetch_latch_stall & ~redirect;
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= FILL;
    else state_q <= state_d;
  always_comb begin
    state_d = redirect ? FILL : fetch_latch_stall ? HOLD : RUN;
  end
  // In FILL the ROM output belongs to a wrong-path or stale address
  always_comb begin
    bubble = (state_q == FILL) | dec_nop | redirect;
  end
  always_comb begin
    imem_addr = imem_addr_mux ? addr_q : pc_q;
    addr_d = imem_addr;
    pc_d = pc_reset ? '0 : int_taken ? INT_VECTOR : pc_load ? pc_load_addr : pc_inc ? pc_q + 1'b1 : pc_q;
    if_instr_d = hold ? if_instr_q : bubble ? NOP_INSTR : imem_data;
    if_pc_d = hold ? if_pc_q : addr_q;
    if_valid_d = hold ? if_valid_q : ~bubble;
    cnt_d = (hold && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc_q <= '0;
      addr_q <= '0;
      if_instr_q <= NOP_INSTR;
      if_pc_q <= '0;
      if_valid_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      pc_q <= pc_d;
      addr_q <= addr_d;
      if_instr_q <= if_instr_d;
      if_pc_q <= if_pc_d;
      if_valid_q <= if_valid_d;
      cnt_q <= cnt_d;
    end
  assign pc = pc_q;
  assign if_instr = if_instr_q;
  assign if_pc = if_pc_q;
  assign if_valid = if_valid_q;
  assign stall_count = cnt_q;
endmodule

// File: tb/tb_pipeline_fetch_unit.sv
// tb_pipeline_fetch_unit: directed scoreboard bench for the fetch stage with an I(a)=a ROM
module tb_pipeline_fetch_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic pc_reset = 1'b0, int_taken = 1'b0, pc_load = 1'b0, pc_inc = 1'b0;
  logic fetch_latch_stall = 1'b0, imem_addr_mux = 1'b0, dec_nop = 1'b0;
  logic [9:0] pc_load_addr = '0;
  logic [9:0] imem_addr, pc, if_pc, rom_q;
  logic [17:0] imem_data, if_instr;
  logic if_valid;
  logic [3:0] stall_count;
  int vectors = 0;
  int errors = 0;
  typedef struct {string tag; logic v; logic [17:0] i; logic [9:0] p; logic [9:0] pc;} exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always_ff @(posedge clk) rom_q <= imem_addr;
  assign imem_data = {8'd0, rom_q};

  pipeline_fetch_unit #(.CNT_WIDTH(4)) dut (
    .clk(clk), .reset(reset), .pc_reset(pc_reset), .int_taken(int_taken),
    .pc_load(pc_load), .pc_load_addr(pc_load_addr), .pc_inc(pc_inc),
    .fetch_latch_stall(fetch_latch_stall), .imem_addr_mux(imem_addr_mux),
    .dec_nop(dec_nop), .imem_addr(imem_addr), .imem_data(imem_data), .pc(pc),
    .if_instr(if_instr), .if_pc(if_pc), .if_valid(if_valid), .stall_count(stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk({e.tag, ".if_valid"}, 32'(if_valid), 32'(e.v));
      chk({e.tag, ".if_instr"}, 32'(if_instr), 32'(e.i));
      chk({e.tag, ".if_pc"}, 32'(if_pc), 32'(e.p));
      chk({e.tag, ".pc"}, 32'(pc), 32'(e.pc));
    end
  endtask

  task automatic step(input string tag, input logic v, input logic [17:0] i, input logic [9:0] p, input logic [9:0] pc_e);
    sb.push_back('{tag, v, i, p, pc_e});
    tick();
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".pc"}, 32'(pc), 0);
    chk({tag, ".if_instr"}, 32'(if_instr), 0);
    chk({tag, ".if_pc"}, 32'(if_pc), 0);
    chk({tag, ".if_valid"}, 32'(if_valid), 0);
    chk({tag, ".stall_count"}, 32'(stall_count), 0);
    chk({tag, ".imem_addr"}, 32'(imem_addr), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    #12;
    chk_reset("reset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    pc_inc = 1'b1;
    step("fill", 0, 18'h0, 10'h0, 10'h1);
    chk("fill.imem_addr", 32'(imem_addr), 1);
    step("run0", 1, 18'h0, 10'h0, 10'h2);
    step("run1", 1, 18'h1, 10'h1, 10'h3);
    step("run2", 1, 18'h2, 10'h2, 10'h4);
    step("run3", 1, 18'h3, 10'h3, 10'h5);
    fetch_latch_stall = 1'b1;
    imem_addr_mux = 1'b1;
    pc_inc = 1'b0;
    #1;
    chk("stall.imem_addr", 32'(imem_addr), 4);
    for (int k = 0; k < 3; k++) begin
      step("stall3", 1, 18'h3, 10'h3, 10'h5);
      chk("stall3.imem_addr", 32'(imem_addr), 4);
      chk("stall3.stall_count", 32'(stall_count), 32'(k + 1));
    end
    fetch_latch_stall = 1'b0;
    imem_addr_mux = 1'b0;
    pc_inc = 1'b1;
    step("release0", 1, 18'h4, 10'h4, 10'h6);
    step("release1", 1, 18'h5, 10'h5, 10'h7);
    chk("release.stall_count", 32'(stall_count), 3);
    pc_load = 1'b1;
    pc_load_addr = 10'h020;
    step("load.bubble", 0, 18'h0, 10'h6, 10'h020);
    pc_load = 1'b0;
    step("load.fill", 0, 18'h0, 10'h7, 10'h021);
    step("load.target", 1, 18'h020, 10'h020, 10'h022);
    step("load.next", 1, 18'h021, 10'h021, 10'h023);
    int_taken = 1'b1;
    pc_load = 1'b1;
    pc_load_addr = 10'h055;
    step("int.prio", 0, 18'h0, 10'h022, 10'h3FF);
    fetch_latch_stall = 1'b1;
    step("int.stall", 0, 18'h0, 10'h023, 10'h3FF);
    chk("int.stall_count", 32'(stall_count), 3);
    int_taken = 1'b0;
    pc_load = 1'b0;
    fetch_latch_stall = 1'b0;
    step("wrap", 0, 18'h0, 10'h3FF, 10'h000);
    step("vector", 1, 18'h3FF, 10'h3FF, 10'h001);
    fetch_latch_stall = 1'b1;
    imem_addr_mux = 1'b1;
    pc_inc = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step("stall20", 1, 18'h3FF, 10'h3FF, 10'h001);
      chk("stall20.stall_count", 32'(stall_count), (k + 4 > 15) ? 15 : 32'(k + 4));
    end
    fetch_latch_stall = 1'b0;
    imem_addr_mux = 1'b0;
    pc_inc = 1'b1;
    step("sat.release0", 1, 18'h0, 10'h0, 10'h2);
    step("sat.release1", 1, 18'h1, 10'h1, 10'h3);
    dec_nop = 1'b1;
    step("nop.bubble", 0, 18'h0, 10'h2, 10'h4);
    dec_nop = 1'b0;
    step("nop.after", 1, 18'h3, 10'h3, 10'h5);
    dec_nop = 1'b1;
    fetch_latch_stall = 1'b1;
    imem_addr_mux = 1'b1;
    pc_inc = 1'b0;
    step("nop.hold", 1, 18'h3, 10'h3, 10'h5);
    chk("nop.hold.stall_count", 32'(stall_count), 15);
    #2;
    reset = 1'b1;
    #1;
    chk_reset("async_reset");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
